// File: rtl/dmem_responder_pkg.sv
// Shared constants and FSM encoding for the MEM-stage data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_responder_pkg;

    localparam int DMEM_WORD_LEN  = 32;
    localparam int DMEM_DEPTH     = 64;
    localparam int DMEM_BASE_ADDR = 1024;
    localparam int DMEM_LATENCY   = 2;
    localparam int DMEM_FSM_LEN   = 2;
    localparam int DMEM_CNT_LEN   = 4;

    typedef enum logic [DMEM_FSM_LEN-1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // WAIT is entered with the number of extra WAIT cycles still to spend.
    function automatic logic [DMEM_CNT_LEN-1:0] cnt_init(input int latency);
        return (latency >= 2) ? DMEM_CNT_LEN'(latency - 2) : '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_LEN word storage with synchronous write and combinational read.
// Latency: write lands on the clock edge, read is same-cycle.
// Backpressure: none; always accepts a write.
module dmem_array #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 64,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [WORD_LEN-1:0] wdata,
    output logic [WORD_LEN-1:0] rdata
);

    logic [WORD_LEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Target end of the MEM-stage load/store request: one access in flight, one-cycle response pulse.
// Latency: response LATENCY cycles after accept (LATENCY in 1..15).
// Backpressure: req_ready low and stall high while an access is waiting; requester holds its request.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WORD_LEN  = DMEM_WORD_LEN,
    parameter int DEPTH     = DMEM_DEPTH,
    parameter int BASE_ADDR = DMEM_BASE_ADDR,
    parameter int LATENCY   = DMEM_LATENCY
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [WORD_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic                stall
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WORD_LEN-1:0] BASE  = WORD_LEN'(BASE_ADDR);
    localparam logic [WORD_LEN-1:0] LIMIT = WORD_LEN'(BASE_ADDR + 4 * DEPTH);

    dmem_state_t             state, state_nxt;
    logic [DMEM_CNT_LEN-1:0] cnt, cnt_nxt;
    logic                    accept;
    logic                    enter_resp;

    logic                    cap_we;
    logic [WORD_LEN-1:0]     cap_addr;
    logic [WORD_LEN-1:0]     cap_wdata;

    logic                    cmt_we;
    logic [WORD_LEN-1:0]     cmt_addr;
    logic [WORD_LEN-1:0]     cmt_wdata;
    logic                    cmt_ok;
    logic [AW-1:0]           cmt_idx;
    logic                    mem_we;
    logic [WORD_LEN-1:0]     mem_rdata;

    logic                    err_q;
    logic                    stall_q;
    logic [WORD_LEN-1:0]     rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state)
            IDLE, RESP: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = cnt_init(LATENCY);
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end
    end

    // With single-cycle latency the access completes on its accept edge, so it
    // must be served straight from the request port rather than the capture regs.
    always_comb begin
        if (LATENCY == 1) begin
            cmt_we    = req_we;
            cmt_addr  = req_addr;
            cmt_wdata = req_wdata;
        end else begin
            cmt_we    = cap_we;
            cmt_addr  = cap_addr;
            cmt_wdata = cap_wdata;
        end
    end

    assign cmt_ok  = (cmt_addr[1:0] == 2'b00) && (cmt_addr >= BASE) && (cmt_addr < LIMIT);
    assign cmt_idx = AW'((cmt_addr - BASE) >> 2);
    assign mem_we  = enter_resp && cmt_we && cmt_ok;

    dmem_array #(
        .WORD_LEN (WORD_LEN),
        .DEPTH    (DEPTH),
        .AW       (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .addr  (cmt_idx),
        .wdata (cmt_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            stall_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            stall_q <= (state_nxt == WAIT);
            if (enter_resp) begin
                err_q <= !cmt_ok;
                if (!cmt_we) begin
                    rdata_q <= cmt_ok ? mem_rdata : '0;
                end
            end
        end
    end

    assign req_ready  = (state != WAIT);
    assign resp_valid = (state == RESP);
    assign resp_err   = err_q && (state == RESP);
    assign resp_rdata = rdata_q;
    assign stall      = stall_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances at LATENCY 2, 1, 4 and 3.
module tb_dmem_responder;

    logic        clk;
    logic        rst        [4];
    logic        req_valid  [4];
    logic        req_we     [4];
    logic [31:0] req_addr   [4];
    logic [31:0] req_wdata  [4];
    logic        req_ready  [4];
    logic        resp_valid [4];
    logic [31:0] resp_rdata [4];
    logic        resp_err   [4];
    logic        stall      [4];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dmem_responder #(
            .WORD_LEN  (32),
            .DEPTH     (64),
            .BASE_ADDR (1024),
            .LATENCY   ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 3)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_ready  (req_ready[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .stall      (stall[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[u] = v;
        req_we[u]    = we;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
    endtask

    task automatic chk_hs(input string tag, input int u,
                          input logic rdy, input logic vld, input logic stl);
        check({tag, ".ready"}, req_ready[u], rdy);
        check({tag, ".valid"}, resp_valid[u], vld);
        check({tag, ".stall"}, stall[u], stl);
    endtask

    task automatic chk_resp(input string tag, input int u, input logic err,
                            input logic [31:0] rdata);
        check({tag, ".valid"}, resp_valid[u], 1'b1);
        check({tag, ".err"}, resp_err[u], err);
        check({tag, ".rdata"}, resp_rdata[u], rdata);
    endtask

    initial begin
        for (int u = 0; u < 4; u++) begin
            rst[u] = 1'b1;
            drive(u, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        repeat (2) step();
        for (int u = 0; u < 4; u++) begin
            chk_hs($sformatf("reset%0d", u), u, 1'b1, 1'b0, 1'b0);
            check($sformatf("reset%0d.err", u), resp_err[u], 1'b0);
            check($sformatf("reset%0d.rdata", u), resp_rdata[u], 32'h0);
            rst[u] = 1'b0;
        end

        // LATENCY 2: store then load of the same word.
        drive(0, 1'b1, 1'b1, 32'd1028, 32'hDEADBEEF);
        step();
        chk_hs("l2.st_wait", 0, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 1'b0, 32'd1028, 32'h0);
        step();
        chk_hs("l2.st_resp", 0, 1'b1, 1'b1, 1'b0);
        chk_resp("l2.st_resp", 0, 1'b0, 32'h0);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk_hs("l2.ld_wait", 0, 1'b0, 1'b0, 1'b1);
        step();
        chk_hs("l2.ld_resp", 0, 1'b1, 1'b1, 1'b0);
        chk_resp("l2.ld_resp", 0, 1'b0, 32'hDEADBEEF);
        step();
        chk_hs("l2.idle", 0, 1'b1, 1'b0, 1'b0);
        check("l2.idle.rdata_hold", resp_rdata[0], 32'hDEADBEEF);

        // LATENCY 1: back-to-back store/load, load accepted in the RESP cycle.
        drive(1, 1'b1, 1'b1, 32'd1024, 32'd5);
        step();
        chk_hs("l1.st_resp", 1, 1'b1, 1'b1, 1'b0);
        chk_resp("l1.st_resp", 1, 1'b0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd1024, 32'h0);
        step();
        chk_hs("l1.ld_resp", 1, 1'b1, 1'b1, 1'b0);
        chk_resp("l1.ld_resp", 1, 1'b0, 32'd5);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk_hs("l1.idle", 1, 1'b1, 1'b0, 1'b0);
        check("l1.idle.rdata_hold", resp_rdata[1], 32'd5);

        // Error cases; 1020 and 1280 alias to words 63 and 0 without the range check.
        drive(1, 1'b1, 1'b0, 32'd1026, 32'h0);
        step();
        chk_resp("err.misalign", 1, 1'b1, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("err.gap.valid", resp_valid[1], 1'b0);
        check("err.gap.err", resp_err[1], 1'b0);
        drive(1, 1'b1, 1'b1, 32'd1020, 32'h11);
        step();
        chk_resp("err.below", 1, 1'b1, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd1024, 32'h0);
        step();
        chk_resp("err.word0", 1, 1'b0, 32'd5);
        drive(1, 1'b1, 1'b0, 32'd1276, 32'h0);
        step();
        chk_resp("err.word63", 1, 1'b0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd1280, 32'h0);
        step();
        chk_resp("err.past_end", 1, 1'b1, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd1024, 32'h0);
        step();
        chk_resp("err.word0_again", 1, 1'b0, 32'd5);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk_hs("err.idle", 1, 1'b1, 1'b0, 1'b0);

        // LATENCY 4 with request held: responses exactly 4 cycles after each accept.
        drive(2, 1'b1, 1'b1, 32'd1040, 32'hA5);
        step();
        chk_hs("l4.e0", 2, 1'b0, 1'b0, 1'b1);
        drive(2, 1'b1, 1'b0, 32'd1040, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            logic exp_vld;
            logic exp_stl;
            step();
            exp_vld = (k == 3) || (k == 7);
            exp_stl = !exp_vld;
            chk_hs($sformatf("l4.e%0d", k), 2, !exp_stl, exp_vld, exp_stl);
            if (k == 3) chk_resp("l4.st_resp", 2, 1'b0, 32'h0);
            if (k == 7) chk_resp("l4.ld_resp", 2, 1'b0, 32'hA5);
        end
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk_hs("l4.idle", 2, 1'b1, 1'b0, 1'b0);

        // LATENCY 3: reset one cycle after accepting a store.
        drive(3, 1'b1, 1'b1, 32'd1032, 32'h77);
        step();
        chk_hs("rst.wait", 3, 1'b0, 1'b0, 1'b1);
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
        rst[3] = 1'b1;
        step();
        rst[3] = 1'b0;
        chk_hs("rst.after", 3, 1'b1, 1'b0, 1'b0);
        check("rst.after.err", resp_err[3], 1'b0);
        check("rst.after.rdata", resp_rdata[3], 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rst.quiet%0d", k), resp_valid[3], 1'b0);
        end
        drive(3, 1'b1, 1'b0, 32'd1032, 32'h0);
        step();
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
        chk_hs("rst.ld_w0", 3, 1'b0, 1'b0, 1'b1);
        step();
        chk_hs("rst.ld_w1", 3, 1'b0, 1'b0, 1'b1);
        step();
        chk_resp("rst.ld_resp", 3, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
